// File: rtl/streaming_dwc_axis.sv
// rtl/streaming_dwc_axis.sv - AXI-Stream data-width converter (up, down or pass-through)
//
// Purpose:
//   Packs narrow input words into wide output words (OUT_WIDTH > IN_WIDTH),
//   splits wide input words into narrow output words (IN_WIDTH > OUT_WIDTH),
//   or acts as a single register slice (equal widths). Element 0 always sits
//   in the LSBs of the wide word.
//
// Optional feature macro: DWC_STATS_EN (adds the xfer_count output port).
//
// Ports:
//   ap_clk          in   clock, rising edge
//   ap_rst_n        in   synchronous active-low reset
//   in0_V_V_TDATA   in   input data  [IN_WIDTH-1:0]
//   in0_V_V_TVALID  in   input valid
//   in0_V_V_TREADY  out  input ready (may depend on out_V_V_TREADY)
//   out_V_V_TDATA   out  output data [OUT_WIDTH-1:0], registered
//   out_V_V_TVALID  out  output valid, registered
//   out_V_V_TREADY  in   output ready
//   xfer_count      out  32-bit output transfer count (DWC_STATS_EN only)

module streaming_dwc_axis #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 24
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
  input  logic                 in0_V_V_TVALID,
  output logic                 in0_V_V_TREADY,
  output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
  output logic                 out_V_V_TVALID,
  input  logic                 out_V_V_TREADY
`ifdef DWC_STATS_EN
  ,
  output logic [31:0]          xfer_count
`endif
);

  localparam int MAX_W = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int MIN_W = (IN_WIDTH > OUT_WIDTH) ? OUT_WIDTH : IN_WIDTH;
  localparam int RATIO = MAX_W / MIN_W;

  if ((MIN_W < 1) || ((MAX_W % MIN_W) != 0)) begin : g_bad_ratio
    $error("streaming_dwc_axis: IN_WIDTH and OUT_WIDTH must be integer multiples");
  end

  logic accept;
  logic pop;

  assign accept = in0_V_V_TVALID && in0_V_V_TREADY;
  assign pop    = out_V_V_TVALID && out_V_V_TREADY;

  if (OUT_WIDTH > IN_WIDTH) begin : g_up
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int ACC_W = (RATIO - 1) * IN_WIDTH;

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last;

    assign last = (cnt_q == CNT_W'(RATIO - 1));

    // Only the final piece needs room in the output register; earlier
    // pieces land in the accumulator regardless of downstream state.
    assign in0_V_V_TREADY = ap_rst_n && (!last || !valid_q || out_V_V_TREADY);
    assign out_V_V_TDATA  = data_q;
    assign out_V_V_TVALID = valid_q;

    always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (pop) begin
        valid_d = 1'b0;
      end
      if (accept) begin
        if (last) begin
          // The final piece goes straight into the MSBs of the output word,
          // so a simultaneous pop is replaced without a bubble.
          data_d  = {in0_V_V_TDATA, acc_q};
          valid_d = 1'b1;
          cnt_d   = '0;
        end else begin
          acc_d[cnt_q*IN_WIDTH +: IN_WIDTH] = in0_V_V_TDATA;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        cnt_q   <= '0;
        acc_q   <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        acc_q   <= acc_d;
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

  end else if (IN_WIDTH > OUT_WIDTH) begin : g_down
    localparam int REM_W = $clog2(RATIO + 1);

    logic [IN_WIDTH-1:0] hold_q, hold_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic                valid_q, valid_d;

    // A new word may enter in the same cycle the last remaining piece leaves.
    assign in0_V_V_TREADY = ap_rst_n &&
                            ((rem_q == '0) || ((rem_q == REM_W'(1)) && out_V_V_TREADY));
    assign out_V_V_TDATA  = hold_q[OUT_WIDTH-1:0];
    assign out_V_V_TVALID = valid_q;

    always_comb begin
      hold_d  = hold_q;
      rem_d   = rem_q;
      valid_d = valid_q;
      if (pop) begin
        hold_d  = hold_q >> OUT_WIDTH;
        rem_d   = rem_q - REM_W'(1);
        valid_d = (rem_q != REM_W'(1));
      end
      if (accept) begin
        hold_d  = in0_V_V_TDATA;
        rem_d   = REM_W'(RATIO);
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        hold_q  <= '0;
        rem_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        hold_q  <= hold_d;
        rem_q   <= rem_d;
        valid_q <= valid_d;
      end
    end

  end else begin : g_equal
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;

    assign in0_V_V_TREADY = ap_rst_n && (!valid_q || out_V_V_TREADY);
    assign out_V_V_TDATA  = data_q;
    assign out_V_V_TVALID = valid_q;

    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (pop) begin
        valid_d = 1'b0;
      end
      if (accept) begin
        data_d  = in0_V_V_TDATA;
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end
  end

`ifdef DWC_STATS_EN
  logic [31:0] xfer_q;

  // Natural 32-bit wrap from 0xFFFFFFFF to 0.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      xfer_q <= '0;
    end else if (pop) begin
      xfer_q <= xfer_q + 32'd1;
    end
  end

  assign xfer_count = xfer_q;
`endif

endmodule
